// File: rtl/pipe_addsub_pkg.sv
// ============================================================================
//  Package    : addsub_pkg
//  Description: Shared constants and helpers for the pipelined add/subtract
//               unit: operation mode encoding and pipeline depth.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package addsub_pkg;

  // Operation mode presented on the sub input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // One register stage per carry segment.
  function automatic int stages(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_addsub_if.sv
// ============================================================================
//  Interface  : pipe_addsub_if
//  Description: Operand/result valid-ready bundle of the pipelined adder.
//               master = operation source / result sink, slave = the adder.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_addsub_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

`default_nettype wire

// File: rtl/pipe_addsub_seg_adder.sv
// ============================================================================
//  Module     : seg_adder
//  Description: Combinational SEG-bit ripple segment. Besides the carry out it
//               exposes the carry into its top bit so the most significant
//               segment can derive signed overflow.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_adder #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] x,
  input  logic [SEG-1:0] y,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb
);

  logic [SEG:0] w_full;

  assign w_full = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
  assign s      = w_full[SEG-1:0];
  assign co     = w_full[SEG];
  // The sum bit is x ^ y ^ carry_in, so the carry into the MSB falls out of it.
  assign c_msb  = s[SEG-1] ^ x[SEG-1] ^ y[SEG-1];

endmodule

`default_nettype wire

// File: rtl/pipe_addsub.sv
// ============================================================================
//  Module     : pipe_addsub
//  Description: Pipelined adder/subtractor. The carry chain is cut into SEG-bit
//               segments with one register stage each; unprocessed operand
//               bits and finished result bits ride in skew registers. A
//               single global advance signal stalls the whole pipe.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_addsub_if.slave  bus
);

  localparam int STAGES = stages(WIDTH, SEG);

  if ((SEG < 1) || (SEG > WIDTH) || ((WIDTH % SEG) != 0)) begin : g_param_check
    $error("pipe_addsub: WIDTH must be a non-zero multiple of SEG");
  end

  logic             w_advance;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c_eff;

  // Whole pipe moves when the output slot is empty or being drained.
  assign w_advance    = !g_stage[STAGES-1].r_v || bus.out_ready;
  assign bus.in_ready = w_advance;

  // Subtract is a + ~b + ~borrow; fold the inversion in before stage 0.
  assign w_b_eff = (bus.sub == OP_SUB) ? ~bus.b   : bus.b;
  assign w_c_eff = (bus.sub == OP_SUB) ? ~bus.cin : bus.cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LOW = k * SEG;        // result bits finished before stage k
    localparam int UPW = WIDTH - LOW;    // operand bits still to be processed
    localparam int REM = UPW - SEG;      // operand bits left after stage k

    logic [UPW-1:0]     w_up_a;
    logic [UPW-1:0]     w_up_b;
    logic               w_ci;
    logic               w_v;
    logic [SEG-1:0]     w_s;
    logic               w_co;
    logic               w_cmsb;
    logic [LOW+SEG-1:0] w_res_next;
    logic [LOW+SEG-1:0] r_res;
    logic               r_c;
    logic               r_v;

    if (k == 0) begin : g_head
      assign w_up_a     = bus.a;
      assign w_up_b     = w_b_eff;
      assign w_ci       = w_c_eff;
      assign w_v        = bus.in_valid;
      assign w_res_next = w_s;
    end else begin : g_body
      assign w_up_a     = g_stage[k-1].g_skew.r_a;
      assign w_up_b     = g_stage[k-1].g_skew.r_b;
      assign w_ci       = g_stage[k-1].r_c;
      assign w_v        = g_stage[k-1].r_v;
      assign w_res_next = {w_s, g_stage[k-1].r_res};
    end

    seg_adder #(
      .SEG (SEG)
    ) u_seg (
      .x     (w_up_a[SEG-1:0]),
      .y     (w_up_b[SEG-1:0]),
      .ci    (w_ci),
      .s     (w_s),
      .co    (w_co),
      .c_msb (w_cmsb)
    );

    // Stage register: valid bit, registered carry and accumulated low result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v   <= 1'b0;
        r_c   <= 1'b0;
        r_res <= '0;
      end else if (w_advance) begin
        r_v   <= w_v;
        r_c   <= w_co;
        r_res <= w_res_next;
      end
    end

    if (REM > 0) begin : g_skew
      logic [REM-1:0] r_a;
      logic [REM-1:0] r_b;

      // Operand skew: carry the not-yet-added upper bits to the next stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_advance) begin
          r_a <= w_up_a[UPW-1:SEG];
          r_b <= w_up_b[UPW-1:SEG];
        end
      end
    end

    if (k == STAGES - 1) begin : g_tail
      logic r_ovf;

      // Signed overflow: carry into the MSB differs from carry out of it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_advance) begin
          r_ovf <= w_co ^ w_cmsb;
        end
      end
    end else begin : g_mid
      // Carry into a middle segment's MSB has no meaning for the result.
      logic w_cmsb_unused;
      assign w_cmsb_unused = w_cmsb;
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].r_v;
  assign bus.sum       = g_stage[STAGES-1].r_res;
  assign bus.cout      = g_stage[STAGES-1].r_c;
  assign bus.ovf       = g_stage[STAGES-1].g_tail.r_ovf;

endmodule

`default_nettype wire
